// File: rtl/key_expand_engine_pkg.sv
// key_expand_engine_pkg: mode encoding, AES schedule sizes and GF(2^8) helpers
package key_expand_engine_pkg;
  typedef enum logic [1:0] {M128 = 2'b00, M192 = 2'b01, M256 = 2'b10, MBAD = 2'b11} mode_t;
  typedef enum logic {IDLE, EXPAND} state_t;
  localparam logic [7:0] RCON_INIT = 8'h01;
  function automatic logic [5:0] nk_of(input mode_t m);
    return m == M256 ? 6'd8 : m == M192 ? 6'd6 : 6'd4;
  endfunction
  function automatic logic [3:0] nr_of(input mode_t m);
    return m == M256 ? 4'd14 : m == M192 ? 4'd12 : 4'd10;
  endfunction
  function automatic logic [5:0] ntot_of(input mode_t m);
    return m == M256 ? 6'd60 : m == M192 ? 6'd52 : 6'd44;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/key_expand_engine_sbox4.sv
// sbox4: four parallel AES S-boxes built from GF(2^8) inversion plus the affine map
module sbox4
  import key_expand_engine_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) begin
      p = p ^ (b[k] ? a : 8'h00);
      a = xtime(a);
    end
    return p;
  endfunction
  // x^254 is the multiplicative inverse and conveniently maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] y, r;
    y = gmul(x, x);
    r = y;
    for (int k = 0; k < 6; k++) begin
      y = gmul(y, y);
      r = gmul(r, y);
    end
    return r;
  endfunction
  function automatic logic [7:0] sbyte(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign dout[8*b +: 8] = sbyte(din[8*b +: 8]);
  end
endmodule

// File: rtl/key_expand_engine.sv
// key_expand_engine: iterative AES-128/192/256 key schedule, one word per cycle,
// with a round-key read port over the stored word array.
module key_expand_engine
  import key_expand_engine_pkg::*;
#(
  parameter logic [2:0] MODE_MASK  = 3'b111,
  parameter bit         RK_REG_OUT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] keyin,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  output logic         err
);
  state_t state, state_n;
  mode_t mode_q;
  logic [31:0] w [60];
  logic [5:0] i, nk, ntot, base;
  logic [3:0] nr;
  logic [2:0] phase;
  logic [7:0] rcon;
  logic [31:0] w_prev, w_back, sub_in, sub_out, temp, w_new;
  logic [127:0] rk_c, rk_q;
  logic mode_ok, accept, reject, last, wrap, rk_ok;
  assign mode_ok = (mode == M128 && MODE_MASK[0]) || (mode == M192 && MODE_MASK[1]) ||
                   (mode == M256 && MODE_MASK[2]);
  assign accept = state == IDLE && start && mode_ok;
  assign reject = state == IDLE && start && !mode_ok;
  assign busy = state == EXPAND;
  assign rk_out = RK_REG_OUT ? rk_q : rk_c;
  sbox4 u_sbox (.din(sub_in), .dout(sub_out));
  always_comb begin
    state_n = accept ? EXPAND : last ? IDLE : state;
  end
  // phase tracks i mod Nk; phase 0 is the RotWord/Rcon word, phase 4 the 256-bit mid-word
  always_comb begin
    nk = nk_of(mode_q);
    nr = nr_of(mode_q);
    ntot = ntot_of(mode_q);
    w_prev = w[i - 6'd1];
    w_back = w[i - nk];
    sub_in = phase == 3'd0 ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    temp = phase == 3'd0 ? sub_out ^ {rcon, 24'h0} :
           (nk == 6'd8 && phase == 3'd4) ? sub_out : w_prev;
    w_new = w_back ^ temp;
    wrap = {3'b000, phase} == nk - 6'd1;
    last = state == EXPAND && i == ntot - 6'd1;
    rk_ok = key_valid && rk_idx <= nr;
    base = rk_ok ? {rk_idx, 2'b00} : 6'd0;
    rk_c = rk_ok ? {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]} : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode_q <= M128;
      i <= '0;
      phase <= '0;
      rcon <= RCON_INIT;
      key_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      rk_q <= '0;
    end else begin
      state <= state_n;
      done <= last;
      err <= reject;
      rk_q <= rk_c;
      if (accept) begin
        mode_q <= mode_t'(mode);
        i <= nk_of(mode_t'(mode));
        phase <= '0;
        rcon <= RCON_INIT;
        key_valid <= 1'b0;
      end else if (state == EXPAND) begin
        i <= i + 6'd1;
        phase <= wrap ? 3'd0 : phase + 3'd1;
        if (phase == 3'd0) rcon <= xtime(rcon);
        if (last) key_valid <= 1'b1;
      end
    end
  end
  // word store is deliberately unreset; rk_out gating hides stale words
  always_ff @(posedge clk) begin
    if (accept) for (int k = 0; k < 8; k++) w[k] <= keyin[255 - 32*k -: 32];
    else if (state == EXPAND) w[i] <= w_new;
  end
endmodule

// File: tb/tb_key_expand_engine.sv
// tb_key_expand_engine: random and directed stimulus against a behavioural AES key-schedule model
module tb_key_expand_engine;
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256 = 128'hfe4890d1e6188d0b046df344706c631e;
  logic clk = 0, rst_n = 0, start = 0, start2 = 0;
  logic [1:0] mode = 0, mode2 = 0;
  logic [255:0] keyin = 0;
  logic [3:0] rk_idx = 0, rk_idx2 = 0;
  logic [127:0] rk_out, rk_out2;
  logic busy, done, key_valid, err, busy2, done2, kv2, err2;
  int checks = 0, fails = 0;
  logic [7:0] sb [256];
  logic [7:0] rct [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  always #5 clk = ~clk;
  key_expand_engine dut (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .keyin(keyin),
    .rk_idx(rk_idx), .rk_out(rk_out), .busy(busy), .done(done), .key_valid(key_valid), .err(err));
  key_expand_engine #(.MODE_MASK(3'b001), .RK_REG_OUT(1'b1)) dut2 (.clk(clk), .rst_n(rst_n),
    .start(start2), .mode(mode2), .keyin(keyin), .rk_idx(rk_idx2), .rk_out(rk_out2),
    .busy(busy2), .done(done2), .key_valid(kv2), .err(err2));
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int nk_f(input logic [1:0] m);
    return m == 2'd2 ? 8 : m == 2'd1 ? 6 : 4;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction
  function automatic logic [127:0] exp_rk(input logic kv, input logic [255:0] key,
                                          input logic [1:0] m, input int idx);
    logic [31:0] w [60];
    logic [31:0] t;
    int nk;
    nk = nk_f(m);
    if (!kv || idx > nk + 6) return '0;
    for (int k = 0; k < nk; k++) w[k] = key[255 - 32*k -: 32];
    for (int j = nk; j < 4*idx + 4; j++) begin
      t = w[j-1];
      if (j % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rct[j/nk - 1], 24'h0};
      else if (nk == 8 && j % nk == 4) t = subw(t);
      w[j] = w[j-nk] ^ t;
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction
  logic m_busy = 0, m_kv = 0, m_done = 0, m_err = 0;
  int m_cnt = 0;
  logic [255:0] m_key = 0;
  logic [1:0] m_mode = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_kv <= 0; m_done <= 0; m_err <= 0; m_cnt <= 0;
    end else begin
      m_done <= 0;
      m_err <= 0;
      if (m_busy) begin
        if (m_cnt == 1) begin m_busy <= 0; m_done <= 1; m_kv <= 1; end
        m_cnt <= m_cnt - 1;
      end else if (start && mode == 2'b11) m_err <= 1;
      else if (start) begin
        m_busy <= 1; m_kv <= 0; m_key <= keyin; m_mode <= mode;
        m_cnt <= 3 * nk_f(mode) + 28;
      end
    end
  end
  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("key_valid", key_valid, m_kv);
    chk("err", err, m_err);
    chk("rk_out", rk_out, exp_rk(m_kv, m_key, m_mode, rk_idx));
  end
  task automatic run(input logic [255:0] k, input logic [1:0] m, input int expn, input int poke);
    int n;
    logic got;
    @(posedge clk); #2 start = 1; mode = m; keyin = k;
    @(posedge clk); #2 start = 0;
    n = 0;
    got = 0;
    while (!got && n < 200) begin
      @(posedge clk); n++;
      #1 got = done;
      #1 start = (n == poke);
      if (n == poke) mode = 2'b01;
    end
    start = 0;
    chk("done_cycles", n, expn);
  endtask
  task automatic read_idx(input logic [3:0] idx, input logic [127:0] exp, input string name);
    @(posedge clk); #2 rk_idx = idx;
    #1 chk(name, rk_out, exp);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] p, q, x;
    int n;
    p = 1; q = 1;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1); q = q ^ (q << 2); q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 1);
    sb[0] = 8'h63;
    chk("model128", exp_rk(1, K128, 0, 10), R128);
    chk("model192", exp_rk(1, K192, 1, 12), R192);
    chk("model256", exp_rk(1, K256, 2, 14), R256);
    repeat (3) @(posedge clk);
    #1 chk("rst_busy", busy, 0);
    chk("rst_kv", key_valid, 0);
    chk("rst_rk", rk_out, 0);
    #1 rst_n = 1;
    run(K128, 0, 40, 0);
    read_idx(10, R128, "rk128_10");
    read_idx(0, K128[255:128], "rk128_0");
    read_idx(11, 0, "rk128_11");
    run(K192, 1, 46, 0);
    read_idx(12, R192, "rk192_12");
    read_idx(13, 0, "rk192_13");
    run(K256, 2, 52, 0);
    read_idx(14, R256, "rk256_14");
    read_idx(15, 0, "rk256_15");
    @(posedge clk); #2 start = 1; mode = 2'b11;
    @(posedge clk); #1 chk("bad_err", err, 1);
    chk("bad_busy", busy, 0);
    chk("bad_kv", key_valid, 1);
    #1 start = 0;
    @(posedge clk); #1 chk("bad_err_pulse", err, 0);
    run(K128, 0, 40, 10);
    read_idx(10, R128, "rk128_poke");
    @(posedge clk); #2 start = 1; mode = 2; keyin = K256;
    @(posedge clk); #2 start = 0;
    repeat (19) @(posedge clk);
    #2 rst_n = 0;
    #1 chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_kv", key_valid, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_rk", rk_out, 0);
    @(posedge clk); #2 rst_n = 1;
    run(K128, 0, 40, 0);
    read_idx(10, R128, "rk128_after_rst");
    @(posedge clk); #2 start2 = 1; mode2 = 2;
    @(posedge clk); #1 chk("mask_err", err2, 1);
    chk("mask_busy", busy2, 0);
    #1 start2 = 0; mode2 = 0; keyin = K128; rk_idx2 = 0;
    @(posedge clk); #2 start2 = 1;
    @(posedge clk); #2 start2 = 0;
    n = 0;
    while (!done2 && n < 100) begin @(posedge clk); n++; #1; end
    chk("reg_done_cycles", n, 40);
    @(posedge clk); #2 rk_idx2 = 10;
    #1 chk("reg_lag", rk_out2, K128[255:128]);
    @(posedge clk); #1 chk("reg_rk10", rk_out2, R128);
    #1 rk_idx2 = 11;
    #1 chk("reg_hold", rk_out2, R128);
    @(posedge clk); #1 chk("reg_rk11", rk_out2, 0);
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 5) == 0);
      mode = 2'($urandom_range(0, 3));
      for (int k = 0; k < 8; k++) keyin[32*k +: 32] = $urandom();
      rk_idx = 4'($urandom_range(0, 15));
    end
    start = 0;
    repeat (60) @(posedge clk);
    #2 rk_idx = 0;
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/key_expand_engine.md
KEY_EXPAND_ENGINE -- requirements
Module: key_expand_engine

Interface
REQ-001 Parameter MODE_MASK, default 3'b111, enables AES-128 (bit0), AES-192 (bit1) and AES-256 (bit2).
REQ-002 Parameter RK_REG_OUT, default 0; when 1, rk_out is registered, giving 1-cycle read latency; when 0, rk_out is combinational.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request expansion; sampled on a rising clk edge.
REQ-006 mode  input  2  key size: 00=128, 01=192, 10=256, 11=illegal.
REQ-007 keyin  input  256  cipher key, w0 in keyin[255:224]; 128-bit mode uses [255:128], 192-bit mode uses [255:64].
REQ-008 rk_idx  input  4  round-key index to read, 0..Nr.
REQ-009 rk_out  output  128  round key {w[4i],w[4i+1],w[4i+2],w[4i+3]}, with w[4i] in [127:96].
REQ-010 busy  output  1  expansion in progress.
REQ-011 done  output  1  one-cycle pulse when expansion completes.
REQ-012 key_valid  output  1  stored schedule is complete and readable.
REQ-013 err  output  1  one-cycle pulse when start is rejected.

Function
REQ-014 Nk/Nr/Ntot SHALL be 4/10/44, 6/12/52, 8/14/60 for 128/192/256.
REQ-015 States SHALL be IDLE and EXPAND; reset enters IDLE.
REQ-016 In IDLE, start with a legal, enabled mode SHALL latch the mode, write w0..w(Nk-1) from keyin, set i=Nk, load rcon=8'h01, and enter EXPAND.
REQ-017 Start with mode 11, or with a mode whose MODE_MASK bit is 0, SHALL pulse err for 1 cycle, leave state and key_valid unchanged, and start nothing.
REQ-018 Start while busy=1 SHALL be ignored; no err pulse.
REQ-019 EXPAND SHALL compute exactly one word per cycle as follows:
  - temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon) (01,02,04,...,80,1b,36).
  - Else if Nk==8 and i mod Nk == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp; then i++.
REQ-020 The i mod Nk test SHALL use a phase counter that wraps at Nk-1, not a divider.
REQ-021 Start sampled at edge 0 SHALL give busy=1 from edge 0 through edge Ntot-Nk; done=1 and key_valid=1 after edge Ntot-Nk (40/46/52 cycles); busy=0 in that same cycle.
REQ-022 key_valid SHALL drop on the edge that accepts a new start and SHALL stay 0 until that expansion's done.
REQ-023 rk_out SHALL be 128'h0 when key_valid=0 or when rk_idx > Nr of the latched mode.
REQ-024 With RK_REG_OUT=1, rk_out SHALL reflect the rk_idx sampled on the previous edge, with the REQ-023 gating applied to that sample.
REQ-025 Start with the same mode and key SHALL reproduce an identical schedule, with no residue from a previous mode.

Reset
REQ-026 rst_n=0 SHALL force IDLE, busy=0, done=0, err=0, key_valid=0, rk_out=0, rcon=8'h01, i=0 immediately, including mid-expansion.
REQ-027 The word store (60x32) SHALL NOT be reset; REQ-023 gating hides stale content.

Structure
REQ-028 A shared package SHALL hold the mode encoding, the Nk/Nr/Ntot constants, the xtime function and the rcon initial value.
REQ-029 One sub-module, SBox4 (the team's 4-byte parallel S-box), SHALL be instantiated exactly once and shared by the RotWord and Nk==8 mid-word substitution paths.

Verification
REQ-030 AES-128, keyin[255:128]=2b7e1516_28aed2a6_abf71588_09cf4f3c -> done 40 cycles after start; rk_idx=10 gives d014f9a8_c9ee2589_e13f0cc8_b6630ca6; rk_idx=0 gives the key.
REQ-031 AES-192, key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b -> done after 46 cycles; rk_idx=12 gives e98ba06f_448c773c_8ecc7204_01002202.
REQ-032 AES-256, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 -> done after 52 cycles; rk_idx=14 gives fe4890d1_e6188d0b_046df344_706c631e; rk_idx=15 gives 0.
REQ-033 mode=11 start -> err pulse, busy stays 0, key_valid unchanged. Second start at cycle 10 of a 128-bit run -> ignored; done still at cycle 40.
REQ-034 rst_n low at cycle 20 of a 256-bit run -> all outputs 0 at once. Restart with the 128-bit vector -> REQ-030 results.
REQ-035 MODE_MASK=3'b001 with mode=10 -> err pulse; RK_REG_OUT=1 -> rk_out lags rk_idx by 1 cycle.
